sum_series_engine: RTL and testbench
====================================

// Module: sum_series_engine
// PURPOSE
//  Parametrised successor of the single-mode summation unit. Computes S = sum(k=1..N) k
//  or S = sum(k=1..N) k^2 over a multi-cycle FSM, then converts S to packed BCD with a
//  sequential double-dabble.
//  Sits between the board switches/start key and the 7-segment display bank.
//  Paced by an internal clock-enable prescaler, not a derived clock.
// PARAMETERS
//  DATA_W   6      width of operand N
//  ACC_W    16     accumulator/result width (saturating)
//  DIGITS   4      BCD digits produced (ACC_W <= 4*DIGITS+3 not required)
//  TICK_DIV 1      FSM advances once every TICK_DIV clocks (1 = every clock, >=1)
// PORTS
//  clk      in   1          system clock
//  rst      in   1          async reset, active-low
//  start    in   1          level; sampled in IDLE/DONE on an enabled tick
//  mode     in   1          0 = sum of k, 1 = sum of k^2; latched at LOAD
//  data     in   DATA_W     operand N; latched at LOAD
//  result   out  ACC_W      binary S (valid while done=1)
//  bcd      out  4*DIGITS   packed BCD of S, digit 0 = LSBs
//  seg      out  7*DIGITS   active-low 7-seg patterns, digit 0 = LSBs
//  status   out  2          {done, busy}
//  overflow out  1          S saturated or S > 10^DIGITS-1
// BEHAVIOUR
//  Reset: state=IDLE; result, bcd, overflow, status = 0; seg = all ones (blank); prescaler = 0.
//  Asserted mid-operation, reset aborts immediately; no partial result is kept.
//  tick = prescaler wrap (every TICK_DIV clocks); all FSM moves below occur on tick only.
//  IDLE: start=1 -> LOAD.
//  LOAD: latch N, mode; acc=0, k=1, sq=1, overflow=0; busy=1 -> ACCUM (N=0 -> CONV).
//  ACCUM: one term per tick.
//   mode0 adds k. mode1 adds sq; sq updated incrementally: sq += 2k+1 (no multiplier).
//   k==N after add -> CONV.
//   Add uses ACC_W+1 bits; carry -> acc = {ACC_W{1}}, overflow=1 (sticky), no further adds
//   change acc.
//  CONV: double-dabble, one shift per tick, ACC_W ticks. If S > 10^DIGITS-1, bcd forced to
//   all 9s and overflow=1 -> DONE.
//  DONE: result/bcd/seg held, status=2'b10. start=1 -> LOAD (restart). Held values remain
//   until the next LOAD.
//  start while busy (LOAD/ACCUM/CONV) is ignored; busy=1 exactly in those states.
//  mode/data changes after LOAD do not affect the running computation.
//  Latency at TICK_DIV=1: start seen -> done = 1 + N + ACC_W + 1 clocks.
//  Multiply by TICK_DIV for slower ticks.
//  result/bcd update only on entry to DONE (no intermediate values visible).
// CONFIGURATION
//  SUM_SEG7_EN defined: seg driven by per-digit BCD->7-seg decoder (0..9 patterns,
//   active-low), refreshed on entry to DONE; leading zeros shown.
//  SUM_SEG7_EN undefined: no decoders built; seg tied to all ones (blank); bcd unaffected.
// TESTING
//  1 mode=0, N=10, start pulse -> done, result=55, bcd=16'h0055, overflow=0.
//  2 mode=0, N=63 -> result=2016, bcd=16'h2016.
//  3 mode=1, N=10 -> result=385.
//  4 mode=1, N=63 -> result=65535 (saturated), bcd=16'h9999, overflow=1.
//  5 N=0 -> result=0, bcd=0, done after 1+ACC_W+1 clocks.
//  6 N=40, rst low during ACCUM, then rerun N=5 -> result=15; a second start while busy has
//    no effect; TICK_DIV=4 run of N=10 takes 4x the clocks.

Source files
------------

// File: rtl/sum_series_engine.sv
// rtl/sum_series_engine.sv - sum-of-k / sum-of-k^2 engine with sequential BCD conversion
//
// Purpose:
//   Computes S = sum(k=1..N) k (mode 0) or S = sum(k=1..N) k^2 (mode 1) one term per
//   tick. The accumulator saturates on overflow. S is then converted to packed BCD by a
//   double-dabble that does one shift per tick. A clock-enable prescaler paces the FSM.
//
// Ports:
//   clk      in   1          system clock
//   rst      in   1          asynchronous reset, active-low
//   start    in   1          level, sampled in IDLE/DONE on a tick
//   mode     in   1          0 = sum of k, 1 = sum of k^2 (latched at LOAD)
//   data     in   DATA_W     operand N (latched at LOAD)
//   result   out  ACC_W      binary S, valid while done=1
//   bcd      out  4*DIGITS   packed BCD of S, digit 0 in the LSBs
//   seg      out  7*DIGITS   active-low 7-segment patterns, digit 0 in the LSBs
//   status   out  2          {done, busy}
//   overflow out  1          S saturated or S > 10^DIGITS-1
//
// Configuration macro:
//   SUM_SEG7_EN - when defined, builds the per-digit BCD->7-segment decoders; otherwise
//                 seg is tied to all ones (blank).

module sum_series_engine #(
  parameter int DATA_W   = 6,
  parameter int ACC_W    = 16,
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_W-1:0]     data,
  output logic [ACC_W-1:0]      result,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic [1:0]            status,
  output logic                  overflow
);

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int KW     = DATA_W + 1;
  // Square register must hold (N+1)^2 after the final incremental update.
  localparam int TERM_W = 2 * DATA_W + 2;
  localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;
  localparam int CW     = $clog2(ACC_W + 1);

  function automatic logic [63:0] pow10(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ACCUM = 3'd2,
    S_CONV  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick;
  logic [DATA_W-1:0]     n_q, n_d;
  logic                  mode_q, mode_d;
  logic [KW-1:0]         k_q, k_d;
  logic [TERM_W-1:0]     sq_q, sq_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   dig_q, dig_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]      result_q, result_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;

  logic [TERM_W-1:0]     term;
  logic [SUM_W-1:0]      sum;
  logic                  sum_ovf;
  logic [4*DIGITS-1:0]   dig_adj;
  logic [4*DIGITS-1:0]   dig_shift;

  // Prescaler: tick on wrap, so the FSM moves once every TICK_DIV clocks.
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_LOAD;
        S_LOAD:  state_d = (data == '0) ? S_CONV : S_ACCUM;
        S_ACCUM: if (k_q == {1'b0, n_q}) state_d = S_CONV;
        S_CONV:  if (cnt_q == CW'(ACC_W - 1)) state_d = S_DONE;
        S_DONE:  if (start) state_d = S_LOAD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    status = 2'b00;
    case (state_q)
      S_LOAD, S_ACCUM, S_CONV: status = 2'b01;
      S_DONE:                  status = 2'b10;
      default:                 status = 2'b00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    term    = mode_q ? sq_q : TERM_W'(k_q);
    sum     = SUM_W'(acc_q) + SUM_W'(term);
    sum_ovf = |sum[SUM_W-1:ACC_W];

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB.
    dig_adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
    dig_shift = {dig_adj[4*DIGITS-2:0], bin_q[ACC_W-1]};

    n_d      = n_q;
    mode_d   = mode_q;
    k_d      = k_q;
    sq_d     = sq_q;
    acc_d    = acc_q;
    bin_d    = bin_q;
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;

    if (tick) begin
      case (state_q)
        S_LOAD: begin
          n_d    = data;
          mode_d = mode;
          acc_d  = '0;
          k_d    = KW'(1);
          sq_d   = TERM_W'(1);
          ovf_d  = 1'b0;
          bin_d  = '0;
          dig_d  = '0;
          cnt_d  = '0;
        end
        S_ACCUM: begin
          // Once saturated the accumulator is frozen; k keeps counting so latency is fixed.
          if (!ovf_q) begin
            if (sum_ovf) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
          end
          // (k+1)^2 = k^2 + 2k + 1
          sq_d = sq_q + TERM_W'({k_q, 1'b1});
          k_d  = k_q + KW'(1);
          if (k_q == {1'b0, n_q}) begin
            bin_d = acc_d;
            dig_d = '0;
            cnt_d = '0;
          end
        end
        S_CONV: begin
          dig_d = dig_shift;
          bin_d = {bin_q[ACC_W-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ACC_W - 1)) begin
            result_d = acc_q;
            if (64'(acc_q) > LIMIT) begin
              bcd_d = {DIGITS{4'h9}};
              ovf_d = 1'b1;
            end else begin
              bcd_d = dig_shift;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      n_q      <= '0;
      mode_q   <= 1'b0;
      k_q      <= '0;
      sq_q     <= '0;
      acc_q    <= '0;
      bin_q    <= '0;
      dig_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      sq_q     <= sq_d;
      acc_q    <= acc_d;
      bin_q    <= bin_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

`ifdef SUM_SEG7_EN
  // Segment order {g,f,e,d,c,b,a}, active-low; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [7*DIGITS-1:0] seg_q, seg_d;

  // Patterns follow bcd_d so they refresh on the same tick that enters DONE.
  always_comb begin
    seg_d = seg_q;
    if (tick && state_q == S_CONV && cnt_q == CW'(ACC_W - 1)) begin
      for (int i = 0; i < DIGITS; i++) seg_d[7*i +: 7] = seg7(bcd_d[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seg_q <= '1;
    else      seg_q <= seg_d;
  end

  assign seg = seg_q;
`else
  assign seg = '1;
`endif

endmodule

// File: tb/tb_sum_series_engine.sv
// tb/tb_sum_series_engine.sv - directed self-checking bench for sum_series_engine

module tb_sum_series_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, mode = 1'b0;
  logic [5:0]  data = '0;
  logic [15:0] result;
  logic [15:0] bcd;
  logic [27:0] seg;
  logic [1:0]  status;
  logic        overflow;

  logic        start4 = 1'b0, mode4 = 1'b0;
  logic [5:0]  data4 = '0;
  logic [15:0] result4;
  logic [15:0] bcd4;
  logic [27:0] seg4;
  logic [1:0]  status4;
  logic        overflow4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sum_series_engine #(.DATA_W(6), .ACC_W(16), .DIGITS(4), .TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .data(data),
    .result(result), .bcd(bcd), .seg(seg), .status(status), .overflow(overflow)
  );

  sum_series_engine #(.DATA_W(6), .ACC_W(16), .DIGITS(4), .TICK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .data(data4),
    .result(result4), .bcd(bcd4), .seg(seg4), .status(status4), .overflow(overflow4)
  );

`ifdef SUM_SEG7_EN
  function automatic logic [27:0] exp_seg(input logic [15:0] b);
    logic [6:0] t [10];
    logic [27:0] s;
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    for (int i = 0; i < 4; i++) s[7*i +: 7] = t[b[4*i +: 4]];
    return s;
  endfunction
`else
  function automatic logic [27:0] exp_seg(input logic [15:0] b);
    return (b == 16'hxxxx) ? 28'h0 : 28'hFFFFFFF;
  endfunction
`endif

  // Drives one job on u_dut; lat = clocks from start asserted to done seen,
  // blat = clocks from busy rising to done rising. -1 on timeout.
  task automatic run_job(input logic [5:0] n, input logic m, output int lat, output int blat);
    int b;
    b   = -1;
    lat = -1;
    @(negedge clk);
    data  = n;
    mode  = m;
    start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (status[0]) begin
        start = 1'b0;
        if (b < 0) b = c;
      end
      if (status[1]) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    blat  = (b < 0 || lat < 0) ? -1 : lat - b;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (status !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b want 00", status); end
    n_cmp++; if (result !== 16'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
    n_cmp++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd got %h want 0000", bcd); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (seg !== 28'hFFFFFFF) begin n_fail++; $display("FAIL reset_seg got %h want fffffff", seg); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sum_k;
    int lat, blat;
    run_job(6'd10, 1'b0, lat, blat);
    n_cmp++; if (result !== 16'd55) begin n_fail++; $display("FAIL k10_result got %0d want 55", result); end
    n_cmp++; if (bcd !== 16'h0055) begin n_fail++; $display("FAIL k10_bcd got %h want 0055", bcd); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL k10_overflow got %b want 0", overflow); end
    n_cmp++; if (status !== 2'b10) begin n_fail++; $display("FAIL k10_status got %b want 10", status); end
    n_cmp++; if (lat !== 28) begin n_fail++; $display("FAIL k10_latency got %0d want 28", lat); end
    n_cmp++; if (blat !== 27) begin n_fail++; $display("FAIL k10_busy_to_done got %0d want 27", blat); end
    n_cmp++; if (seg !== exp_seg(16'h0055)) begin n_fail++; $display("FAIL k10_seg got %h want %h", seg, exp_seg(16'h0055)); end
    run_job(6'd63, 1'b0, lat, blat);
    n_cmp++; if (result !== 16'd2016) begin n_fail++; $display("FAIL k63_result got %0d want 2016", result); end
    n_cmp++; if (bcd !== 16'h2016) begin n_fail++; $display("FAIL k63_bcd got %h want 2016", bcd); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL k63_overflow got %b want 0", overflow); end
    n_cmp++; if (lat !== 81) begin n_fail++; $display("FAIL k63_latency got %0d want 81", lat); end
  endtask

  task automatic test_sum_sq;
    int lat, blat;
    run_job(6'd10, 1'b1, lat, blat);
    n_cmp++; if (result !== 16'd385) begin n_fail++; $display("FAIL sq10_result got %0d want 385", result); end
    n_cmp++; if (bcd !== 16'h0385) begin n_fail++; $display("FAIL sq10_bcd got %h want 0385", bcd); end
    run_job(6'd1, 1'b1, lat, blat);
    n_cmp++; if (result !== 16'd1) begin n_fail++; $display("FAIL sq1_result got %0d want 1", result); end
    run_job(6'd30, 1'b1, lat, blat);
    n_cmp++; if (bcd !== 16'h9455) begin n_fail++; $display("FAIL sq30_bcd got %h want 9455", bcd); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sq30_overflow got %b want 0", overflow); end
    run_job(6'd31, 1'b1, lat, blat);
    n_cmp++; if (result !== 16'd10416) begin n_fail++; $display("FAIL sq31_result got %0d want 10416", result); end
    n_cmp++; if (bcd !== 16'h9999) begin n_fail++; $display("FAIL sq31_bcd got %h want 9999", bcd); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sq31_overflow got %b want 1", overflow); end
    run_job(6'd63, 1'b1, lat, blat);
    n_cmp++; if (result !== 16'hFFFF) begin n_fail++; $display("FAIL sq63_result got %0d want 65535", result); end
    n_cmp++; if (bcd !== 16'h9999) begin n_fail++; $display("FAIL sq63_bcd got %h want 9999", bcd); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sq63_overflow got %b want 1", overflow); end
  endtask

  task automatic test_zero;
    int lat, blat;
    run_job(6'd0, 1'b0, lat, blat);
    n_cmp++; if (result !== 16'd0) begin n_fail++; $display("FAIL n0_result got %0d want 0", result); end
    n_cmp++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL n0_bcd got %h want 0000", bcd); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL n0_overflow_cleared got %b want 0", overflow); end
    n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL n0_latency got %0d want 18", lat); end
  endtask

  task automatic test_reset_abort;
    int lat, blat;
    @(negedge clk);
    data  = 6'd40;
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if (status !== 2'b01) begin n_fail++; $display("FAIL abort_busy_before got %b want 01", status); end
    rst = 1'b0;
    #1;
    n_cmp++; if (status !== 2'b00) begin n_fail++; $display("FAIL abort_status got %b want 00", status); end
    n_cmp++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL abort_bcd got %h want 0000", bcd); end
    @(negedge clk);
    rst = 1'b1;
    run_job(6'd5, 1'b0, lat, blat);
    n_cmp++; if (result !== 16'd15) begin n_fail++; $display("FAIL rerun5_result got %0d want 15", result); end
    n_cmp++; if (bcd !== 16'h0015) begin n_fail++; $display("FAIL rerun5_bcd got %h want 0015", bcd); end
  endtask

  task automatic test_back_to_back;
    int lat, blat;
    lat = -1;
    @(negedge clk);
    data  = 6'd20;
    mode  = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      // Retrigger and change operands while busy; must not disturb the running job.
      if (c == 5) begin start = 1'b1; data = 6'd63; mode = 1'b1; end
      if (c == 8) start = 1'b0;
      if (status[1]) begin lat = c; break; end
    end
    start = 1'b0;
    n_cmp++; if (result !== 16'd210) begin n_fail++; $display("FAIL busy_start_result got %0d want 210", result); end
    n_cmp++; if (lat !== 38) begin n_fail++; $display("FAIL busy_start_latency got %0d want 38", lat); end
    run_job(6'd3, 1'b1, lat, blat);
    n_cmp++; if (result !== 16'd14) begin n_fail++; $display("FAIL restart_result got %0d want 14", result); end
    n_cmp++; if (lat !== 21) begin n_fail++; $display("FAIL restart_latency got %0d want 21", lat); end
  endtask

  task automatic test_tick_div;
    int b, d;
    b = -1;
    d = -1;
    @(negedge clk);
    data4  = 6'd10;
    mode4  = 1'b0;
    start4 = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (status4[0]) begin
        start4 = 1'b0;
        if (b < 0) b = c;
      end
      if (status4[1]) begin d = c; break; end
    end
    start4 = 1'b0;
    n_cmp++; if (result4 !== 16'd55) begin n_fail++; $display("FAIL div4_result got %0d want 55", result4); end
    n_cmp++; if (bcd4 !== 16'h0055) begin n_fail++; $display("FAIL div4_bcd got %h want 0055", bcd4); end
    n_cmp++; if ((b < 0 || d < 0) || (d - b) !== 108) begin
      n_fail++; $display("FAIL div4_busy_to_done got %0d want 108", (b < 0 || d < 0) ? -1 : d - b);
    end
  endtask

  initial begin
    test_reset();
    test_sum_k();
    test_sum_sq();
    test_zero();
    test_reset_abort();
    test_back_to_back();
    test_tick_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
